// File: rtl/uart_spi_bridge.sv
// UART-to-SPI bridge: queues received UART bytes, sends each one over SPI, and
// returns every SPI response byte on the UART transmitter.
module uart_spi_bridge #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    uart_rx_data,
  input  logic                          uart_rx_valid,
  input  logic                          spi_busy,
  input  logic [7:0]                    spi_rx_data,
  input  logic                          spi_rx_valid,
  input  logic                          uart_tx_ready,
  output logic [7:0]                    spi_tx_data,
  output logic                          spi_start,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout,
  output logic                          bridge_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SPI_WAIT,
    UART_SEND,
    UART_WAIT_LOW,
    UART_WAIT_HIGH
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [7:0]      resp_q, resp_d;
  logic [7:0]      spi_tx_q, uart_tx_q;
  logic            overflow_q, overflow_d;
  logic            timeout_q, timeout_d;
  logic            spi_start_c, uart_start_c;
  logic            fifo_full, push_ok;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign tcnt_inc  = tcnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    resp_d       = resp_q;
    timeout_d    = timeout_q;
    spi_start_c  = 1'b0;
    uart_start_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0 && !spi_busy) begin
          spi_start_c = 1'b1;
          tcnt_d      = '0;
          state_d     = SPI_WAIT;
        end
      end
      SPI_WAIT: begin
        if (spi_rx_valid) begin
          resp_d  = spi_rx_data;
          state_d = UART_SEND;
        end else begin
          tcnt_d = tcnt_inc;
          // Flag rises exactly TIMEOUT_CYCLES cycles after the spi_start pulse.
          if (tcnt_inc == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      UART_SEND: begin
        if (uart_tx_ready) begin
          uart_start_c = 1'b1;
          state_d      = UART_WAIT_LOW;
        end
      end
      UART_WAIT_LOW:  if (!uart_tx_ready) state_d = UART_WAIT_HIGH;
      UART_WAIT_HIGH: if (uart_tx_ready)  state_d = IDLE;
      default:        state_d = IDLE;
    endcase
    // Launch pulses are suppressed while reset is asserted.
    if (reset) begin
      spi_start_c  = 1'b0;
      uart_start_c = 1'b0;
    end
  end

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign push_ok    = uart_rx_valid && (!fifo_full || spi_start_c);
  assign overflow_d = overflow_q | (uart_rx_valid && fifo_full && !spi_start_c);

  always_comb begin
    count_d = count_q;
    if (push_ok && !spi_start_c)      count_d = count_q + 1'b1;
    else if (!push_ok && spi_start_c) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tcnt_q     <= '0;
      resp_q     <= '0;
      spi_tx_q   <= '0;
      uart_tx_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tcnt_q     <= tcnt_d;
      resp_q     <= resp_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (spi_start_c) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        spi_tx_q <= mem_q[rd_ptr_q];
      end
      if (uart_start_c) uart_tx_q <= resp_q;
    end
  end

  // Data buses show the new byte during the launch pulse, then hold it.
  assign spi_start     = spi_start_c;
  assign spi_tx_data   = spi_start_c ? mem_q[rd_ptr_q] : spi_tx_q;
  assign uart_tx_start = uart_start_c;
  assign uart_tx_data  = uart_start_c ? resp_q : uart_tx_q;
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign timeout       = timeout_q;
  assign bridge_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Directed bench for uart_spi_bridge: single byte, burst, full FIFO with
// simultaneous pop, overflow, SPI timeout and reset mid-transaction.
module tb_uart_spi_bridge;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic       spi_busy;
  logic [7:0] spi_rx_data;
  logic       spi_rx_valid;
  logic       uart_tx_ready;
  logic [7:0] spi_tx_data;
  logic       spi_start;
  logic [7:0] uart_tx_data;
  logic       uart_tx_start;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       timeout;
  logic       bridge_busy;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  uart_spi_bridge #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .spi_busy(spi_busy), .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .uart_tx_ready(uart_tx_ready),
    .spi_tx_data(spi_tx_data), .spi_start(spi_start),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .fifo_count(fifo_count), .overflow(overflow), .timeout(timeout),
    .bridge_busy(bridge_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Both launch pulses must never coincide.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      assert (!(spi_start && uart_tx_start)) else begin
        bad++;
        $error("FAIL dual_start observed=%b%b expected=not both", spi_start, uart_tx_start);
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Called during an SPI_WAIT cycle: return resp and complete the UART handshake.
  task automatic respond(input logic [7:0] resp, input string tag);
    spi_rx_data = resp; spi_rx_valid = 1'b1;
    next(); spi_rx_valid = 1'b0;
    look();
    chk({tag, "_ustart"}, uart_tx_start, 1);
    chk({tag, "_udata"}, uart_tx_data, resp);
    next(); uart_tx_ready = 1'b0;
    next(); uart_tx_ready = 1'b1;
    next();
  endtask

  task automatic serve(input logic [7:0] exp_tx, input logic [7:0] resp, input string tag);
    int n = 0;
    look();
    while (spi_start !== 1'b1 && n < 40) begin
      next(); look(); n++;
    end
    chk({tag, "_sstart"}, spi_start, 1);
    chk({tag, "_stx"}, spi_tx_data, exp_tx);
    next();
    respond(resp, tag);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; uart_rx_data = '0; uart_rx_valid = 1'b0; spi_busy = 1'b0;
    spi_rx_data = '0; spi_rx_valid = 1'b0; uart_tx_ready = 1'b1;
    next(); next(); look();
    chk("rst_start", spi_start, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", bridge_busy, 0);
    chk("rst_flags", {overflow, timeout}, 0);
    chk("rst_data", {spi_tx_data, uart_tx_data}, 0);
    next(); reset = 1'b0; mon_en = 1'b1;

    // Stray SPI response while idle is ignored.
    spi_rx_data = 8'h77; spi_rx_valid = 1'b1;
    next(); spi_rx_valid = 1'b0; look();
    chk("stray_busy", bridge_busy, 0);

    // Single byte.
    next(); uart_rx_data = 8'hA5; uart_rx_valid = 1'b1; look();
    chk("single_nosame", spi_start, 0);
    next(); uart_rx_valid = 1'b0; look();
    chk("single_start", spi_start, 1);
    chk("single_tx", spi_tx_data, 8'hA5);
    chk("single_cnt1", fifo_count, 1);
    next(); uart_tx_ready = 1'b0; look();
    chk("single_busy", bridge_busy, 1);
    chk("single_cnt0", fifo_count, 0);
    chk("single_hold", spi_tx_data, 8'hA5);
    spi_rx_data = 8'h3C; spi_rx_valid = 1'b1;
    next(); spi_rx_valid = 1'b0; look();
    chk("single_uwait", uart_tx_start, 0);
    next(); uart_tx_ready = 1'b1; look();
    chk("single_ustart", uart_tx_start, 1);
    chk("single_udata", uart_tx_data, 8'h3C);
    next(); look();
    chk("single_upulse", uart_tx_start, 0);
    chk("single_uhold", uart_tx_data, 8'h3C);
    next(); uart_tx_ready = 1'b0;
    next(); uart_tx_ready = 1'b1;
    next(); look();
    chk("single_idle", bridge_busy, 0);

    // Burst 01..04 back to back.
    next(); uart_rx_data = 8'h01; uart_rx_valid = 1'b1; look();
    chk("burst_nosame", spi_start, 0);
    next(); uart_rx_data = 8'h02; look();
    chk("burst_s1", spi_start, 1);
    chk("burst_tx1", spi_tx_data, 8'h01);
    next(); uart_rx_data = 8'h03;
    next(); uart_rx_data = 8'h04;
    next(); uart_rx_valid = 1'b0; look();
    chk("burst_cnt", fifo_count, 3);
    respond(8'h81, "burst1");
    serve(8'h02, 8'h82, "burst2");
    serve(8'h03, 8'h83, "burst3");
    serve(8'h04, 8'h84, "burst4");
    look();
    chk("burst_ovf", overflow, 0);
    chk("burst_empty", fifo_count, 0);

    // Full FIFO with a push coinciding with dispatch.
    next(); spi_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 8'h10 + 8'(i); uart_rx_valid = 1'b1; next();
    end
    spi_busy = 1'b0; uart_rx_data = 8'h14; look();
    chk("full_cnt", fifo_count, 4);
    chk("full_start", spi_start, 1);
    chk("full_tx", spi_tx_data, 8'h10);
    next(); uart_rx_valid = 1'b0; look();
    chk("full_cnt_keep", fifo_count, 4);
    chk("full_ovf", overflow, 0);
    respond(8'h90, "full0");
    serve(8'h11, 8'h91, "full1");
    serve(8'h12, 8'h92, "full2");
    serve(8'h13, 8'h93, "full3");
    serve(8'h14, 8'h94, "full4");

    // Overflow: six pushes while SPI is busy.
    spi_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      uart_rx_data = 8'h20 + 8'(i); uart_rx_valid = 1'b1; next();
    end
    uart_rx_valid = 1'b0; look();
    chk("ovf_cnt", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    next(); spi_busy = 1'b0;
    serve(8'h20, 8'hA0, "ovf0");
    serve(8'h21, 8'hA1, "ovf1");
    serve(8'h22, 8'hA2, "ovf2");
    serve(8'h23, 8'hA3, "ovf3");
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      look(); if (spi_start) cnt++; next();
    end
    chk("ovf_no_extra", cnt, 0);
    chk("ovf_sticky", overflow, 1);

    reset = 1'b1; next(); reset = 1'b0; look();
    chk("rst2_ovf", overflow, 0);

    // Timeout, then next byte dispatched.
    next(); spi_busy = 1'b1;
    uart_rx_data = 8'h30; uart_rx_valid = 1'b1; next();
    uart_rx_data = 8'h31; next();
    uart_rx_valid = 1'b0; spi_busy = 1'b0; look();
    chk("tmo_start", spi_start, 1);
    chk("tmo_tx", spi_tx_data, 8'h30);
    cnt = 0;
    for (int k = 1; k < TMO; k++) begin
      next(); look(); if (uart_tx_start) cnt++;
    end
    chk("tmo_early", timeout, 0);
    chk("tmo_wait_busy", bridge_busy, 1);
    next(); look();
    chk("tmo_flag", timeout, 1);
    chk("tmo_next_start", spi_start, 1);
    chk("tmo_next_tx", spi_tx_data, 8'h31);
    chk("tmo_no_uart", cnt, 0);

    // Reset while in SPI_WAIT with two bytes queued.
    next(); uart_rx_data = 8'h32; uart_rx_valid = 1'b1;
    next(); uart_rx_data = 8'h33;
    next(); uart_rx_valid = 1'b0; look();
    chk("rstw_cnt2", fifo_count, 2);
    chk("rstw_busy1", bridge_busy, 1);
    next(); reset = 1'b1; look();
    chk("rstw_nostart", spi_start, 0);
    next(); reset = 1'b0; look();
    chk("rstw_cnt0", fifo_count, 0);
    chk("rstw_busy0", bridge_busy, 0);
    chk("rstw_tmo", timeout, 0);
    chk("rstw_release", spi_start, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      next(); look(); if (spi_start) cnt++;
    end
    chk("rstw_quiet", cnt, 0);
    next(); uart_rx_data = 8'h40; uart_rx_valid = 1'b1;
    next(); uart_rx_valid = 1'b0;
    serve(8'h40, 8'hC0, "after_rst");

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
